// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Optional zero-divisor early exit and div_zero flag under SEQDIV_ZERO_CHECK_EN.
module seq_divider #(
  parameter int NUM_W = 6,
  parameter int DEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
`ifdef SEQDIV_ZERO_CHECK_EN
  output logic [DEN_W-1:0] remain,
  output logic             div_zero
`else
  output logic [DEN_W-1:0] remain
`endif
);

  localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] num_sh;
  logic [DEN_W-1:0] den_r;
  logic [DEN_W:0]   rem_r;
  logic [DEN_W:0]   p;
  logic [DEN_W:0]   diff;
  logic             q_bit;
  logic             last_bit;
  logic             zero_hit;
  logic             accept;
  logic             finish;

  // The partial remainder MSB is never set after a restoring step; if it were,
  // the subtraction would have to be forced, so it is folded into q_bit.
  always_comb begin
    p        = {rem_r[DEN_W-1:0], num_sh[NUM_W-1]};
    diff     = p - {1'b0, den_r};
    q_bit    = rem_r[DEN_W] | (p >= {1'b0, den_r});
    last_bit = (cnt == '0);
`ifdef SEQDIV_ZERO_CHECK_EN
    zero_hit = (den_r == '0);
`else
    zero_hit = 1'b0;
`endif
    accept   = (state == S_IDLE) && start;
    finish   = (state == S_RUN) && (last_bit || zero_hit);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_bit || zero_hit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  assign busy = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      num_sh <= '0;
      den_r  <= '0;
      rem_r  <= '0;
    end else if (accept) begin
      cnt    <= CNT_W'(NUM_W - 1);
      num_sh <= numer;
      den_r  <= denom;
      rem_r  <= '0;
    end else if (state == S_RUN) begin
      cnt    <= cnt - 1'b1;
      num_sh <= {num_sh[NUM_W-2:0], q_bit};
      rem_r  <= q_bit ? diff : p;
    end
  end

  // Result registers only change on the finishing edge, so they hold through busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      quotient <= '0;
      remain   <= '0;
`ifdef SEQDIV_ZERO_CHECK_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= finish;
      if (finish) begin
        if (zero_hit) begin
          quotient <= '1;
          remain   <= '0;
        end else begin
          quotient <= {num_sh[NUM_W-2:0], q_bit};
          remain   <= q_bit ? diff[DEN_W-1:0] : p[DEN_W-1:0];
        end
`ifdef SEQDIV_ZERO_CHECK_EN
        div_zero <= zero_hit;
`endif
      end
    end
  end

endmodule
